// File: rtl/bcd_display_pkg.sv
// Shared types and the BCD-to-segment table for the display multiplexer.
package bcd_display_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } state_t;

  // Active-high patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0   = 7'h3F;
  localparam logic [6:0] SEG_1   = 7'h06;
  localparam logic [6:0] SEG_2   = 7'h5B;
  localparam logic [6:0] SEG_3   = 7'h4F;
  localparam logic [6:0] SEG_4   = 7'h66;
  localparam logic [6:0] SEG_5   = 7'h6D;
  localparam logic [6:0] SEG_6   = 7'h7D;
  localparam logic [6:0] SEG_7   = 7'h07;
  localparam logic [6:0] SEG_8   = 7'h7F;
  localparam logic [6:0] SEG_9   = 7'h6F;
  localparam logic [6:0] SEG_ERR = 7'h40;

  // Non-BCD nibbles show a lone dash so a converter fault is visible on the board.
  function automatic logic [6:0] bcd2seg(input logic [3:0] bcd);
    logic [6:0] seg;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_ERR;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD nibble to active-high 7-segment pattern.
module bcd_to_7seg
  import bcd_display_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  assign seg_o = bcd2seg(bcd_i);

endmodule

// File: rtl/bcd_display_mux.sv
// Requests conversions from the binary-to-BCD converter, latches the result
// and scans it onto a multiplexed 7-segment display.
//
//   state | meaning
//   IDLE  | no requests issued; waiting for Enable
//   REQ   | Start high for this single cycle
//   WAIT  | conversion in flight; next Done latches DataBCD
//   HOLD  | value latched; next request on update_req
module bcd_display_mux
  import bcd_display_pkg::*;
#(
  parameter int DEC_DIGITS        = 2,
  parameter int CLK_DIV           = 1000,
  parameter int FRAMES_PER_UPDATE = 16,
  parameter int ACTIVE_LOW        = 1,
  parameter int BLANK_LZ          = 1
) (
  input  logic                    Clk,
  input  logic                    Rst_n,
  input  logic                    Enable,
  input  logic [DEC_DIGITS*4-1:0] DataBCD,
  input  logic                    Done,
  output logic                    Start,
  output logic [6:0]              Seg,
  output logic [DEC_DIGITS-1:0]   Anode
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int DW = (DEC_DIGITS > 1) ? $clog2(DEC_DIGITS) : 1;
  localparam int FW = (FRAMES_PER_UPDATE > 1) ? $clog2(FRAMES_PER_UPDATE) : 1;

  // Inactive output levels; XOR with these applies the board polarity.
  localparam logic [6:0]            SEG_OFF = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic [DEC_DIGITS-1:0] AN_OFF  = (ACTIVE_LOW != 0) ? {DEC_DIGITS{1'b1}}
                                                                : {DEC_DIGITS{1'b0}};

  logic [PW-1:0]           presc_q, presc_d;
  logic [DW-1:0]           dig_q, dig_d;
  logic [FW-1:0]           frame_q, frame_d;
  state_t                  state_q, state_d;
  logic [DEC_DIGITS*4-1:0] val_q, val_d;
  logic [6:0]              seg_q, seg_d;
  logic [DEC_DIGITS-1:0]   anode_q, anode_d;

  logic                    update_req;
  logic [3:0]              nib;
  logic [6:0]              seg_raw;
  logic [DEC_DIGITS-1:0]   onehot;
  logic [DEC_DIGITS-1:0]   blank;
  logic                    zero_run;

  // Free-running scan: prescaler, digit index and frame counter.
  always_comb begin
    presc_d    = presc_q + 1'b1;
    dig_d      = dig_q;
    frame_d    = frame_q;
    update_req = 1'b0;
    if (presc_q == PW'(CLK_DIV - 1)) begin
      presc_d = '0;
      if (dig_q == DW'(DEC_DIGITS - 1)) begin
        dig_d = '0;
        if (frame_q == FW'(FRAMES_PER_UPDATE - 1)) begin
          frame_d    = '0;
          update_req = 1'b1;
        end else begin
          frame_d = frame_q + 1'b1;
        end
      end else begin
        dig_d = dig_q + 1'b1;
      end
    end
  end

  // Request/latch sequencing; Start is a decode of the REQ state.
  always_comb begin
    state_d = state_q;
    val_d   = val_q;
    Start   = 1'b0;
    case (state_q)
      IDLE: if (Enable) state_d = REQ;
      REQ: begin
        Start   = 1'b1;
        state_d = WAIT;
      end
      WAIT: if (Done) begin
        val_d   = DataBCD;
        state_d = Enable ? HOLD : IDLE;
      end
      HOLD: begin
        if (!Enable)         state_d = IDLE;
        else if (update_req) state_d = REQ;
      end
      default: state_d = IDLE;
    endcase
  end

  // Digit select and leading-zero mask; scanning from the top digit down keeps
  // a running "everything above and including me is zero" flag.
  always_comb begin
    nib      = 4'd0;
    onehot   = '0;
    blank    = '0;
    zero_run = 1'b1;
    for (int i = DEC_DIGITS - 1; i >= 0; i--) begin
      zero_run = zero_run && (val_q[4*i +: 4] == 4'd0);
      if (i > 0 && BLANK_LZ != 0) blank[i] = zero_run;
      if (dig_q == DW'(i)) begin
        nib       = val_q[4*i +: 4];
        onehot[i] = 1'b1;
      end
    end
    seg_d   = seg_raw ^ SEG_OFF;
    anode_d = (onehot & ~blank) ^ AN_OFF;
  end

  bcd_to_7seg u_seg (
    .bcd_i (nib),
    .seg_o (seg_raw)
  );

  // State, latch and output registers; outputs go inactive the moment reset asserts.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      presc_q <= '0;
      dig_q   <= '0;
      frame_q <= '0;
      state_q <= IDLE;
      val_q   <= '0;
      seg_q   <= SEG_OFF;
      anode_q <= AN_OFF;
    end else begin
      presc_q <= presc_d;
      dig_q   <= dig_d;
      frame_q <= frame_d;
      state_q <= state_d;
      val_q   <= val_d;
      seg_q   <= seg_d;
      anode_q <= anode_d;
    end
  end

  assign Seg   = seg_q;
  assign Anode = anode_q;

endmodule

// File: tb/tb_bcd_display_mux.sv
// Randomized bench for bcd_display_mux against a cycle-level reference model.
// Two instances share stimulus: active-high with blanking, active-low without.
module tb_bcd_display_mux;

  localparam int CD  = 4;
  localparam int DD  = 2;
  localparam int FPU = 2;
  localparam int P   = CD * DD * FPU;

  localparam logic [6:0] SEG_TAB [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                          7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  logic       Clk = 1'b0;
  logic       Rst_n = 1'b0;
  logic       Enable = 1'b0;
  logic       Done = 1'b0;
  logic [7:0] DataBCD = 8'h00;
  logic       Start, Start_b;
  logic [6:0] Seg, Seg_b;
  logic [1:0] Anode, Anode_b;

  always #5 Clk = ~Clk;

  bcd_display_mux #(.DEC_DIGITS(DD), .CLK_DIV(CD), .FRAMES_PER_UPDATE(FPU),
                    .ACTIVE_LOW(0), .BLANK_LZ(1)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Enable(Enable), .DataBCD(DataBCD), .Done(Done),
    .Start(Start), .Seg(Seg), .Anode(Anode));

  bcd_display_mux #(.DEC_DIGITS(DD), .CLK_DIV(CD), .FRAMES_PER_UPDATE(FPU),
                    .ACTIVE_LOW(1), .BLANK_LZ(0)) dut_b (
    .Clk(Clk), .Rst_n(Rst_n), .Enable(Enable), .DataBCD(DataBCD), .Done(Done),
    .Start(Start_b), .Seg(Seg_b), .Anode(Anode_b));

  int total = 0;
  int bad   = 0;

  // Reference model: cycle index since reset release plus request bookkeeping.
  int         k;
  bit         m_start, m_wait, m_hold;
  logic [7:0] m_val;
  bit         e_start, e_dark;
  logic [6:0] e_seg, e_seg_b;
  logic [1:0] e_an, e_an_b;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [6:0] pat_of(input logic [3:0] n);
    if (n > 4'd9) return 7'h40;
    return SEG_TAB[n];
  endfunction

  task automatic model_reset();
    k       = 0;
    m_start = 0;
    m_wait  = 0;
    m_hold  = 0;
    m_val   = 8'h00;
    e_start = 0;
    e_dark  = 0;
    e_seg   = 7'h00;
    e_an    = 2'b00;
    e_seg_b = 7'h7F;
    e_an_b  = 2'b11;
  endtask

  // Advance the model across one rising edge using the inputs the DUT sampled.
  task automatic model_edge();
    int         d;
    bit         upd;
    logic [7:0] sh;
    logic [6:0] pat;
    logic [1:0] oh;
    d   = (k / CD) % DD;
    upd = ((k + 1) % P) == 0;
    sh  = m_val >> (4 * d);
    pat = pat_of(sh[3:0]);
    oh  = 2'(1 << d);
    e_dark  = (d > 0) && (sh == 8'h00);
    e_seg   = pat;
    e_an    = e_dark ? 2'b00 : oh;
    e_seg_b = ~pat;
    e_an_b  = ~oh;
    if (m_start) begin
      m_start = 0;
      m_wait  = 1;
    end else if (m_wait) begin
      if (Done) begin
        m_val  = DataBCD;
        m_wait = 0;
        m_hold = Enable;
      end
    end else if (m_hold) begin
      if (!Enable) m_hold = 0;
      else if (upd) begin
        m_hold  = 0;
        m_start = 1;
      end
    end else if (Enable) begin
      m_start = 1;
    end
    e_start = m_start;
    k++;
  endtask

  task automatic compare_all(input string ph);
    chk({ph, ".start"}, 32'(Start), 32'(e_start));
    chk({ph, ".anode"}, 32'(Anode), 32'(e_an));
    if (!e_dark) chk({ph, ".seg"}, 32'(Seg), 32'(e_seg));
    chk({ph, ".start_b"}, 32'(Start_b), 32'(e_start));
    chk({ph, ".anode_b"}, 32'(Anode_b), 32'(e_an_b));
    chk({ph, ".seg_b"}, 32'(Seg_b), 32'(e_seg_b));
  endtask

  task automatic step(input string ph);
    @(posedge Clk);
    model_edge();
    @(negedge Clk);
    compare_all(ph);
  endtask

  // n cycles; each expected Start is answered with Done after dly cycles.
  task automatic run(input string ph, input int n, input bit en, input int dly,
                     input bit rnd, input logic [7:0] data, input bit noise, input bit drop);
    int cnt;
    cnt    = 0;
    Enable = en;
    for (int j = 0; j < n; j++) begin
      step(ph);
      Done = 1'b0;
      if (noise && cnt == 0 && $urandom_range(0, 7) == 0) begin
        Done    = 1'b1;
        DataBCD = 8'($urandom);
      end
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          Done    = 1'b1;
          DataBCD = rnd ? 8'($urandom) : data;
        end
      end
      if (e_start) begin
        cnt = dly;
        if (drop) Enable = 1'b0;
      end
    end
    Done = 1'b0;
  endtask

  task automatic check_inactive(input string ph);
    chk({ph, ".start"}, 32'(Start), 32'h0);
    chk({ph, ".seg"}, 32'(Seg), 32'h00);
    chk({ph, ".anode"}, 32'(Anode), 32'h0);
    chk({ph, ".start_b"}, 32'(Start_b), 32'h0);
    chk({ph, ".seg_b"}, 32'(Seg_b), 32'h7F);
    chk({ph, ".anode_b"}, 32'(Anode_b), 32'h3);
  endtask

  initial begin
    bit seen;
    model_reset();
    repeat (3) @(negedge Clk);
    check_inactive("reset");
    compare_all("reset_model");
    Rst_n = 1'b1;

    run("idle", 40, 1'b0, 3, 1'b0, 8'h00, 1'b0, 1'b0);
    run("h42",  60, 1'b1, 3, 1'b0, 8'h42, 1'b0, 1'b0);
    run("h07",  40, 1'b1, 3, 1'b0, 8'h07, 1'b0, 1'b0);
    run("hA5",  40, 1'b1, 2, 1'b0, 8'hA5, 1'b0, 1'b0);
    run("noise", 60, 1'b1, 4, 1'b0, 8'h31, 1'b1, 1'b0);
    run("drop", 50, 1'b1, 3, 1'b0, 8'h13, 1'b1, 1'b1);
    for (int r = 0; r < 8; r++)
      run("rand", $urandom_range(20, 70), 1'($urandom_range(0, 1)), $urandom_range(1, 6),
          1'b1, 8'h00, 1'b1, 1'($urandom_range(0, 1)));

    // Async reset in the middle of an outstanding conversion.
    Enable = 1'b1;
    seen   = 0;
    for (int j = 0; j < 3 * P && !seen; j++) begin
      step("to_wait");
      if (e_start) seen = 1;
    end
    if (!seen) chk("to_wait.timeout", 32'h0, 32'h1);
    step("in_wait");
    #1 Rst_n = 1'b0;
    #1 check_inactive("rst_async");
    model_reset();
    Enable = 1'b0;
    repeat (2) @(negedge Clk);
    check_inactive("rst_held");
    Rst_n = 1'b1;
    run("after_rst", 24, 1'b0, 3, 1'b0, 8'h00, 1'b0, 1'b0);
    run("reen", 40, 1'b1, 5, 1'b0, 8'h90, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
